mem_port_arbiter: RTL and testbench

Shares the single 16-bit memory port between two masters: the CPU (instruction fetch and data access) and a secondary master (DMA/debug loader).
- Arbitration is zero-latency and combinational: the granted command drives the memory port in the same cycle.
- Read returns are routed back to the issuing master by a tag pipeline matched to the fixed memory read latency.
- CPU has fixed priority. An anti-starvation counter guarantees the secondary master a slot.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter_rd_tag_pipe.sv | 35 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-master memory port arbiter.
// Holds the master identifiers, the read-return tag carried down the
// latency pipeline and a small saturating-increment helper.
package mem_arb_pkg;

    typedef enum logic {
        M_CPU = 1'b0,
        M_SEC = 1'b1
    } master_id_t;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rd_tag_t;

    localparam int MAX_RD_LAT = 4;

    localparam rd_tag_t TAG_NONE = '{valid: 1'b0, id: M_CPU};

    // Increment a 16-bit counter, holding at all-ones instead of wrapping.
    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memory port.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives the commands and models the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    logic [ADDR_W-1:0] i_m0_addr;
    logic              i_m0_rd;
    logic              i_m0_wr;
    logic [DATA_W-1:0] i_m0_wrdata;
    logic              o_m0_waitrequest;
    logic [DATA_W-1:0] o_m0_rddata;
    logic              o_m0_rddatavalid;

    logic [ADDR_W-1:0] i_m1_addr;
    logic              i_m1_rd;
    logic              i_m1_wr;
    logic [DATA_W-1:0] i_m1_wrdata;
    logic              o_m1_waitrequest;
    logic [DATA_W-1:0] o_m1_rddata;
    logic              o_m1_rddatavalid;

    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_rd;
    logic              o_mem_wr;
    logic [DATA_W-1:0] o_mem_wrdata;
    logic [DATA_W-1:0] i_mem_rddata;

    modport slave (
        input  i_m0_addr, i_m0_rd, i_m0_wr, i_m0_wrdata,
        output o_m0_waitrequest, o_m0_rddata, o_m0_rddatavalid,
        input  i_m1_addr, i_m1_rd, i_m1_wr, i_m1_wrdata,
        output o_m1_waitrequest, o_m1_rddata, o_m1_rddatavalid,
        output o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
        input  i_mem_rddata
    );

    modport master (
        output i_m0_addr, i_m0_rd, i_m0_wr, i_m0_wrdata,
        input  o_m0_waitrequest, o_m0_rddata, o_m0_rddatavalid,
        output i_m1_addr, i_m1_rd, i_m1_wr, i_m1_wrdata,
        input  o_m1_waitrequest, o_m1_rddata, o_m1_rddatavalid,
        input  o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
        output i_mem_rddata
    );

endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Read-return tag pipeline.
// A plain RD_LAT-deep shift register of {valid, id}. Whatever is pushed
// in a cycle pops out exactly RD_LAT cycles later, lining up with the
// memory's fixed read latency. Reset empties every stage so reads that
// were in flight never produce a response.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t push_i,
    output rd_tag_t pop_o
);

    rd_tag_t stage_q [RD_LAT];

    // Shift one stage per clock; stage 0 takes the new tag every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q[0] <= push_i;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign pop_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single memory port.
// The CPU (m0) has fixed priority; the secondary master (m1) is forced
// through once it has been refused STARVE_LIM cycles in a row. The grant
// is combinational, so the winning command reaches the memory in the
// same cycle. Read data is steered back using a tag pipeline whose depth
// equals the memory read latency RD_LAT (1..MAX_RD_LAT).
// Optional build macro MEM_ARB_PERF_CNT_EN adds a saturating counter of
// cycles in which both masters request; without it o_conflict_cnt is 0.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic [15:0]       o_conflict_cnt
);

    localparam int STARVE_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    logic              req0;
    logic              req1;
    logic              starved;
    logic              grant0;
    logic              grant1;

    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWrdata;
    logic              memRd;
    logic              memWr;

    logic [STARVE_W-1:0] starveCnt_q;
    logic [STARVE_W-1:0] starveCnt_d;

    rd_tag_t           pushTag;
    rd_tag_t           popTag;
    logic              rdValid0;
    logic              rdValid1;

    // Decide who owns the port this cycle; nobody wins while in reset.
    always_comb begin
        req0    = bus.i_m0_rd | bus.i_m0_wr;
        req1    = bus.i_m1_rd | bus.i_m1_wr;
        starved = (starveCnt_q == STARVE_W'(STARVE_LIM));
        grant0  = 1'b0;
        grant1  = 1'b0;
        if (!reset) begin
            grant1 = req1 && (!req0 || starved);
            grant0 = req0 && !grant1;
        end
    end

    // A requesting master that lost is told to hold; in reset both hold.
    assign bus.o_m0_waitrequest = reset | (req0 & ~grant0);
    assign bus.o_m1_waitrequest = reset | (req1 & ~grant1);

    // Steer the winner's command onto the memory port. A command with
    // both rd and wr set is forwarded as a write only.
    always_comb begin
        memAddr   = '0;
        memWrdata = '0;
        memRd     = 1'b0;
        memWr     = 1'b0;
        if (grant0) begin
            memAddr   = bus.i_m0_addr;
            memWrdata = bus.i_m0_wrdata;
            memWr     = bus.i_m0_wr;
            memRd     = bus.i_m0_rd & ~bus.i_m0_wr;
        end else if (grant1) begin
            memAddr   = bus.i_m1_addr;
            memWrdata = bus.i_m1_wrdata;
            memWr     = bus.i_m1_wr;
            memRd     = bus.i_m1_rd & ~bus.i_m1_wr;
        end
    end

    assign bus.o_mem_addr   = memAddr;
    assign bus.o_mem_wrdata = memWrdata;
    assign bus.o_mem_rd     = memRd;
    assign bus.o_mem_wr     = memWr;

    // Count consecutive refusals of m1; stop counting at the limit, which
    // is the value that forces m1 through on its next request.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!req1 || grant1) begin
            starveCnt_d = '0;
        end else if (!starved) begin
            starveCnt_d = starveCnt_q + STARVE_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

    // Tag every cycle with whether a read went out and who issued it.
    always_comb begin
        pushTag.valid = memRd;
        pushTag.id    = grant1 ? M_SEC : M_CPU;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tagPipe (
        .clk    (clk),
        .reset  (reset),
        .push_i (pushTag),
        .pop_o  (popTag)
    );

    // Route the returning data to the tagged master; the other sees zero.
    always_comb begin
        rdValid0             = !reset && popTag.valid && (popTag.id == M_CPU);
        rdValid1             = !reset && popTag.valid && (popTag.id == M_SEC);
        bus.o_m0_rddatavalid = rdValid0;
        bus.o_m1_rddatavalid = rdValid1;
        bus.o_m0_rddata      = rdValid0 ? bus.i_mem_rddata : '0;
        bus.o_m1_rddata      = rdValid1 ? bus.i_mem_rddata : '0;
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] conflictCnt_q;
    logic [15:0] conflictCnt_d;

    // Next conflict count: bump on every cycle both masters want the port.
    always_comb begin
        conflictCnt_d = conflictCnt_q;
        if (req0 && req1) begin
            conflictCnt_d = satInc16(conflictCnt_q);
        end
    end

    // Conflict counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflictCnt_q <= 16'h0000;
        end else begin
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign o_conflict_cnt = conflictCnt_q;
`else
    assign o_conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// Three instances with RD_LAT = 1, 2, 3 share the same master stimulus
// and read-data input. A reference model decides grants from the
// arbitration rules and predicts read returns from a per-cycle history
// of issued reads and reset cycles. Honours MEM_ARB_PERF_CNT_EN.
module tb_mem_port_arbiter;

    localparam int STARVE_LIM = 4;
    localparam int NDUT       = 3;
    localparam int HIST       = 4096;

    logic clk;
    logic reset;
    logic m0Rd, m0Wr, m1Rd, m1Wr;
    logic [15:0] m0Addr, m0Wd, m1Addr, m1Wd, memRdData;

    logic [NDUT-1:0] wait0, wait1, memRd, memWr, rdv0, rdv1;
    logic [NDUT-1:0][15:0] memAddr, memWd, rdata0, rdata1, conflict;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

        assign bus.i_m0_addr    = m0Addr;
        assign bus.i_m0_rd      = m0Rd;
        assign bus.i_m0_wr      = m0Wr;
        assign bus.i_m0_wrdata  = m0Wd;
        assign bus.i_m1_addr    = m1Addr;
        assign bus.i_m1_rd      = m1Rd;
        assign bus.i_m1_wr      = m1Wr;
        assign bus.i_m1_wrdata  = m1Wd;
        assign bus.i_mem_rddata = memRdData;

        assign wait0[g]   = bus.o_m0_waitrequest;
        assign wait1[g]   = bus.o_m1_waitrequest;
        assign rdv0[g]    = bus.o_m0_rddatavalid;
        assign rdv1[g]    = bus.o_m1_rddatavalid;
        assign rdata0[g]  = bus.o_m0_rddata;
        assign rdata1[g]  = bus.o_m1_rddata;
        assign memRd[g]   = bus.o_mem_rd;
        assign memWr[g]   = bus.o_mem_wr;
        assign memAddr[g] = bus.o_mem_addr;
        assign memWd[g]   = bus.o_mem_wrdata;

        mem_port_arbiter #(
            .RD_LAT     (g + 1),
            .STARVE_LIM (STARVE_LIM),
            .ADDR_W     (16),
            .DATA_W     (16)
        ) dut (
            .clk            (clk),
            .reset          (reset),
            .bus            (bus),
            .o_conflict_cnt (conflict[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int cyc       = 0;
    int streak    = 0;
    int conflicts = 0;
    bit histRd    [HIST];
    bit histId    [HIST];
    bit histReset [HIST];
    logic mReq0, mReq1, mG0, mG1;
    logic expW0, expW1, expMemRd, expMemWr;
    logic [15:0] expAddr, expWd;
    logic acc0, acc1;

    typedef struct {
        logic        rd0, wr0;
        logic [15:0] a0, d0;
        logic        rd1, wr1;
        logic [15:0] a1, d1;
        logic        eW0, eW1, eRd, eWr;
        logic [15:0] eAddr, eWd;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input int lat,
                               input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s lat=%0d cyc=%0d got=%h exp=%h", name, lat, cyc, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd0, input logic wr0, input logic [15:0] a0,
                                 input logic [15:0] d0, input logic rd1, input logic wr1,
                                 input logic [15:0] a1, input logic [15:0] d1);
        m0Rd = rd0; m0Wr = wr0; m0Addr = a0; m0Wd = d0;
        m1Rd = rd1; m1Wr = wr1; m1Addr = a1; m1Wd = d1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // A read issued lat cycles ago returns now, unless a reset cycle fell
    // anywhere between the issue and now (inclusive of now).
    function automatic logic expValid(input int lat, input bit id);
        if (cyc < lat) return 1'b0;
        if (!histRd[cyc-lat] || histId[cyc-lat] != id) return 1'b0;
        for (int k = cyc - lat + 1; k <= cyc; k++) begin
            if (histReset[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelEval();
        mReq0 = m0Rd | m0Wr;
        mReq1 = m1Rd | m1Wr;
        mG0 = 1'b0;
        mG1 = 1'b0;
        if (!reset) begin
            mG1 = mReq1 && (!mReq0 || streak == STARVE_LIM);
            mG0 = mReq0 && !mG1;
        end
        expW0 = reset || (mReq0 && !mG0);
        expW1 = reset || (mReq1 && !mG1);
        expMemRd = 1'b0; expMemWr = 1'b0; expAddr = 16'h0; expWd = 16'h0;
        if (mG0) begin
            expAddr = m0Addr; expWd = m0Wd; expMemWr = m0Wr; expMemRd = m0Rd && !m0Wr;
        end else if (mG1) begin
            expAddr = m1Addr; expWd = m1Wd; expMemWr = m1Wr; expMemRd = m1Rd && !m1Wr;
        end
        histRd[cyc]    = expMemRd;
        histId[cyc]    = mG1;
        histReset[cyc] = reset;
        acc0 = mReq0 && !expW0;
        acc1 = mReq1 && !expW1;
    endtask

    task automatic modelAdvance();
        if (reset) begin
            streak = 0;
            conflicts = 0;
        end else begin
            if (!mReq1 || mG1) streak = 0;
            else if (streak < STARVE_LIM) streak++;
            if (mReq0 && mReq1 && conflicts < 65535) conflicts++;
        end
        cyc++;
    endtask

    task automatic compareAll();
        logic ev0, ev1;
        logic [15:0] expConf;
        for (int g = 0; g < NDUT; g++) begin
            ev0 = expValid(g + 1, 1'b0);
            ev1 = expValid(g + 1, 1'b1);
`ifdef MEM_ARB_PERF_CNT_EN
            expConf = 16'(conflicts);
`else
            expConf = 16'h0;
`endif
            checkOutput("wait0", g + 1, 16'(wait0[g]), 16'(expW0));
            checkOutput("wait1", g + 1, 16'(wait1[g]), 16'(expW1));
            checkOutput("memRd", g + 1, 16'(memRd[g]), 16'(expMemRd));
            checkOutput("memWr", g + 1, 16'(memWr[g]), 16'(expMemWr));
            checkOutput("memAddr", g + 1, memAddr[g], expAddr);
            checkOutput("memWd", g + 1, memWd[g], expWd);
            checkOutput("rdv0", g + 1, 16'(rdv0[g]), 16'(ev0));
            checkOutput("rdv1", g + 1, 16'(rdv1[g]), 16'(ev1));
            checkOutput("rdata0", g + 1, rdata0[g], ev0 ? memRdData : 16'h0);
            checkOutput("rdata1", g + 1, rdata1[g], ev1 ? memRdData : 16'h0);
            checkOutput("conflict", g + 1, conflict[g], expConf);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        modelEval();
        compareAll();
    endtask

    task automatic advance();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        applyIdle();
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic p0, p1;
        int r;

        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h1111};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0200, 16'h1234,
                    1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h1234};
        vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h2222, 1'b1, 1'b0, 16'h0030, 16'h3333,
                    1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h2222};
        vecs[3] = '{1'b0, 1'b1, 16'h0040, 16'hAAAA, 1'b0, 1'b1, 16'h0050, 16'h5555,
                    1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'hAAAA};
        vecs[4] = '{1'b1, 1'b1, 16'h0004, 16'h7777, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h7777};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0300, 16'h0BAD,
                    1'b0, 1'b0, 1'b0, 1'b1, 16'h0300, 16'h0BAD};

        reset = 1'b1;
        memRdData = 16'h0;
        applyIdle();
        @(posedge clk);
        #1;
        idleCycles(2);
        reset = 1'b0;

        // Reset-state check on the first idle cycle after reset
        settle();
        for (int g = 0; g < NDUT; g++) begin
            checkOutput("rstWait0", g + 1, 16'(wait0[g]), 16'h0);
            checkOutput("rstConf", g + 1, conflict[g], 16'h0);
        end
        advance();

        // Single-cycle grant table, each vector separated by an idle cycle
        $display("[TB] grant table");
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].rd0, vecs[v].wr0, vecs[v].a0, vecs[v].d0,
                          vecs[v].rd1, vecs[v].wr1, vecs[v].a1, vecs[v].d1);
            settle();
            for (int g = 0; g < NDUT; g++) begin
                checkOutput("tblWait0", v, 16'(wait0[g]), 16'(vecs[v].eW0));
                checkOutput("tblWait1", v, 16'(wait1[g]), 16'(vecs[v].eW1));
                checkOutput("tblMemRd", v, 16'(memRd[g]), 16'(vecs[v].eRd));
                checkOutput("tblMemWr", v, 16'(memWr[g]), 16'(vecs[v].eWr));
                checkOutput("tblAddr", v, memAddr[g], vecs[v].eAddr);
                checkOutput("tblWd", v, memWd[g], vecs[v].eWd);
            end
            advance();
            idleCycles(1);
        end
        idleCycles(4);

        // m0 read alone, RD_LAT=1 returns BEEF next cycle
        $display("[TB] m0 single read");
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        settle();
        checkOutput("rd1Wait0", 1, 16'(wait0[0]), 16'h0);
        checkOutput("rd1MemRd", 1, 16'(memRd[0]), 16'h1);
        advance();
        applyIdle();
        memRdData = 16'hBEEF;
        settle();
        checkOutput("rd1Valid0", 1, 16'(rdv0[0]), 16'h1);
        checkOutput("rd1Data0", 1, rdata0[0], 16'hBEEF);
        checkOutput("rd1Valid1", 1, 16'(rdv1[0]), 16'h0);
        advance();
        idleCycles(4);

        // Both masters read continuously: m1 wins every fifth cycle
        $display("[TB] starvation pattern");
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0, 1'b1, 1'b0, 16'h0180, 16'h0);
        for (int k = 0; k < 10; k++) begin
            memRdData = 16'(16'h4000 + k);
            settle();
            checkOutput("stvWait1", k, 16'(wait1[0]), (k % 5 == 4) ? 16'h0 : 16'h1);
            checkOutput("stvWait0", k, 16'(wait0[0]), (k % 5 == 4) ? 16'h1 : 16'h0);
            if (k == 5) begin
`ifdef MEM_ARB_PERF_CNT_EN
                checkOutput("stvConf", k, conflict[0], 16'd5);
`else
                checkOutput("stvConf", k, conflict[0], 16'd0);
`endif
            end
            advance();
        end
        idleCycles(4);

        // m1 write with m0 idle
        $display("[TB] m1 write");
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0200, 16'h1234);
        settle();
        checkOutput("wrMemWr", 1, 16'(memWr[0]), 16'h1);
        checkOutput("wrMemAddr", 1, memAddr[0], 16'h0200);
        checkOutput("wrMemWd", 1, memWd[0], 16'h1234);
        advance();
        idleCycles(2);
        settle();
        checkOutput("wrNoRdv1", 3, 16'(rdv1[2]), 16'h0);
        advance();

        // Alternating reads m0, m1, m0 through the RD_LAT=3 instance
        $display("[TB] alternating reads lat3");
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
                1: applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0101, 16'h0);
                2: applyStimulus(1'b1, 1'b0, 16'h0102, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
                default: applyIdle();
            endcase
            memRdData = 16'(16'hD000 + k);
            settle();
            if (k == 3) begin
                checkOutput("altV0a", 3, 16'(rdv0[2]), 16'h1);
                checkOutput("altD0a", 3, rdata0[2], 16'hD003);
                checkOutput("altV1a", 3, 16'(rdv1[2]), 16'h0);
            end else if (k == 4) begin
                checkOutput("altV1b", 3, 16'(rdv1[2]), 16'h1);
                checkOutput("altD1b", 3, rdata1[2], 16'hD004);
                checkOutput("altV0b", 3, 16'(rdv0[2]), 16'h0);
            end else if (k == 5) begin
                checkOutput("altV0c", 3, 16'(rdv0[2]), 16'h1);
                checkOutput("altD0c", 3, rdata0[2], 16'hD005);
            end
            advance();
        end
        idleCycles(3);

        // Reset one cycle after an accepted read on the RD_LAT=2 instance
        $display("[TB] reset drops in-flight read");
        for (int k = 0; k < 5; k++) begin
            if (k == 0) applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
            else applyIdle();
            reset = (k == 1);
            memRdData = 16'(16'hE000 + k);
            settle();
            if (k >= 1) checkOutput("rstNoRdv0", k, 16'(rdv0[1]), 16'h0);
            if (k == 1) begin
                checkOutput("rstHoldW0", k, 16'(wait0[1]), 16'h1);
                checkOutput("rstHoldW1", k, 16'(wait1[1]), 16'h1);
                checkOutput("rstMemRd", k, 16'(memRd[1]), 16'h0);
            end
            if (k >= 2) begin
                checkOutput("postW0", k, 16'(wait0[1]), 16'h0);
                checkOutput("postW1", k, 16'(wait1[1]), 16'h0);
            end
            advance();
        end
        applyStimulus(1'b1, 1'b0, 16'h0310, 16'h0, 1'b1, 1'b0, 16'h0320, 16'h0);
        for (int k = 0; k < 5; k++) begin
            settle();
            checkOutput("postStv", k, 16'(wait1[1]), (k == 4) ? 16'h0 : 16'h1);
            advance();
        end
        idleCycles(4);

        // rd and wr together from m0: write only, no read response
        $display("[TB] rd+wr together");
        applyStimulus(1'b1, 1'b1, 16'h0004, 16'h9999, 1'b0, 1'b0, 16'h0, 16'h0);
        settle();
        checkOutput("bothMemWr", 0, 16'(memWr[0]), 16'h1);
        checkOutput("bothMemRd", 0, 16'(memRd[0]), 16'h0);
        checkOutput("bothAddr", 0, memAddr[0], 16'h0004);
        advance();
        applyIdle();
        for (int k = 1; k <= 4; k++) begin
            settle();
            for (int g = 0; g < NDUT; g++) begin
                checkOutput("bothNoRdv0", g + 1, 16'(rdv0[g]), 16'h0);
            end
            advance();
        end

        // Randomized traffic against the model
        $display("[TB] random traffic");
        p0 = 1'b0;
        p1 = 1'b0;
        applyIdle();
        for (int n = 0; n < 1500; n++) begin
            if (!p0) begin
                m0Rd = 1'b0; m0Wr = 1'b0;
                if ($urandom_range(0, 9) < 6) begin
                    p0 = 1'b1;
                    r = int'($urandom_range(0, 19));
                    m0Rd = (r < 10) || (r == 19);
                    m0Wr = (r >= 10);
                    m0Addr = 16'($urandom);
                    m0Wd = 16'($urandom);
                end
            end
            if (!p1) begin
                m1Rd = 1'b0; m1Wr = 1'b0;
                if ($urandom_range(0, 9) < 5) begin
                    p1 = 1'b1;
                    r = int'($urandom_range(0, 19));
                    m1Rd = (r < 10) || (r == 19);
                    m1Wr = (r >= 10);
                    m1Addr = 16'($urandom);
                    m1Wd = 16'($urandom);
                end
            end
            reset = ($urandom_range(0, 99) == 0);
            memRdData = 16'($urandom);
            settle();
            if (acc0) p0 = 1'b0;
            if (acc1) p1 = 1'b0;
            advance();
        end
        reset = 1'b0;
        idleCycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
